// File: rtl/obstacle_field_ctl.sv
// obstacle_field_ctl: scrolls N_OBST obstacles leftward, respawns them with LFSR heights,
// detects player collision, and keeps a saturating score with score-driven speed-up.
module obstacle_field_ctl #(
    parameter int          N_OBST        = 2,
    parameter int          TICK_DIV      = 4_000_000,
    parameter int          X_START       = 750,
    parameter int          SPACING       = 200,
    parameter int          Y_MIN         = 100,
    parameter int          Y_BITS        = 8,
    parameter int          OBST_W        = 32,
    parameter int          OBST_H        = 32,
    parameter int          PLAYER_X      = 0,
    parameter int          PLAYER_W      = 48,
    parameter int          PLAYER_H      = 48,
    parameter int          SPEEDUP_EVERY = 5,
    parameter int          MAX_STEP      = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [11:0]         player_y_i,
    output logic [12*N_OBST-1:0] obstacle_xpos_o,
    output logic [12*N_OBST-1:0] obstacle_ypos_o,
    output logic                endgame_o,
    output logic [15:0]         score_o,
    output logic [2:0]          step_o
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, RUN, ENDGAME} state_t;
    state_t        state_q;
    logic [11:0]   xpos_q [N_OBST];
    logic [11:0]   ypos_q [N_OBST];
    logic [15:0]   score_q, spd_q, lfsr_q, lfsr_d, score_d;
    logic [2:0]    step_q;
    logic [TW-1:0] tick_q;
    logic          endgame_q, tick;
    logic [N_OBST-1:0] hit, exits;
    logic [3:0]    n_exit;
    logic [16:0]   score_sum, spd_d;
    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign tick      = tick_q == TW'(TICK_DIV - 1);
    assign score_sum = {1'b0, score_q} + 17'(n_exit);
    assign score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    assign spd_d     = {1'b0, spd_q} + 17'(n_exit);
    // Overlap test widened to 13 bits so edge sums never wrap.
    always_comb begin
        hit    = '0;
        exits  = '0;
        n_exit = '0;
        for (int i = 0; i < N_OBST; i++) begin
            hit[i]   = ({1'b0, xpos_q[i]} < 13'(PLAYER_X + PLAYER_W)) &&
                       ({1'b0, xpos_q[i]} + 13'(OBST_W) > 13'(PLAYER_X)) &&
                       ({1'b0, ypos_q[i]} < {1'b0, player_y_i} + 13'(PLAYER_H)) &&
                       ({1'b0, ypos_q[i]} + 13'(OBST_H) > {1'b0, player_y_i});
            exits[i] = xpos_q[i] < 12'(step_q);
            n_exit   = n_exit + 4'(exits[i]);
        end
    end
    always_ff @(posedge clk) begin
        lfsr_q <= rst ? LFSR_SEED : lfsr_d;
        if (rst || (start_i && state_q != RUN)) begin
            state_q   <= rst ? IDLE : RUN;
            for (int i = 0; i < N_OBST; i++) begin
                xpos_q[i] <= 12'(X_START + i * SPACING);
                ypos_q[i] <= 12'(Y_MIN + (i * 37) % (1 << Y_BITS));
            end
            score_q   <= '0;
            step_q    <= 3'd1;
            tick_q    <= '0;
            spd_q     <= '0;
            endgame_q <= 1'b0;
        end else if (state_q == RUN) begin
            if (|hit) begin
                state_q   <= ENDGAME;
                endgame_q <= 1'b1;
            end else if (tick) begin
                tick_q <= '0;
                for (int i = 0; i < N_OBST; i++) begin
                    xpos_q[i] <= exits[i] ? 12'(X_START) : xpos_q[i] - 12'(step_q);
                    ypos_q[i] <= exits[i] ? 12'(Y_MIN) + 12'(lfsr_q[Y_BITS-1:0]) : ypos_q[i];
                end
                score_q <= score_d;
                if (spd_d >= 17'(SPEEDUP_EVERY)) begin
                    spd_q <= '0;
                    if (step_q < 3'(MAX_STEP)) step_q <= step_q + 3'd1;
                end else begin
                    spd_q <= spd_d[15:0];
                end
            end else begin
                tick_q <= tick_q + TW'(1);
            end
        end
    end
    for (genvar g = 0; g < N_OBST; g++) begin : g_pack
        assign obstacle_xpos_o[12*g +: 12] = xpos_q[g];
        assign obstacle_ypos_o[12*g +: 12] = ypos_q[g];
    end
    assign endgame_o = endgame_q;
    assign score_o   = score_q;
    assign step_o    = step_q;
endmodule

// File: tb/tb_obstacle_field_ctl.sv
// tb_obstacle_field_ctl: random-stimulus bench comparing obstacle_field_ctl against a
// game-level model (positions, score, speed, collision) kept in plain integers.
module tb_obstacle_field_ctl;
    logic        clk = 0, rst = 1, start_i = 0;
    logic [11:0] player_y_i = 12'd900;
    logic [23:0] xpos_o, ypos_o, xpos2_o, ypos2_o;
    logic        endgame_o, endgame2_o;
    logic [15:0] score_o, score2_o;
    logic [2:0]  step_o, step2_o;
    int total = 0, bad = 0;
    int mx[2], my[2], msc, mstep, mtick, mspd, mst, m_exits;
    bit [15:0] ml = 16'hACE1;

    obstacle_field_ctl #(.N_OBST(2), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .player_y_i(player_y_i),
        .obstacle_xpos_o(xpos_o), .obstacle_ypos_o(ypos_o),
        .endgame_o(endgame_o), .score_o(score_o), .step_o(step_o));
    obstacle_field_ctl #(.N_OBST(2), .TICK_DIV(4), .SPACING(0)) dut2 (
        .clk(clk), .rst(rst), .start_i(start_i), .player_y_i(player_y_i),
        .obstacle_xpos_o(xpos2_o), .obstacle_ypos_o(ypos2_o),
        .endgame_o(endgame2_o), .score_o(score2_o), .step_o(step2_o));

    always #5 clk = ~clk;

    function automatic logic [67:0] exp_out();
        return {12'(mx[1]), 12'(mx[0]), 12'(my[1]), 12'(my[0]), 16'(msc), 3'(mstep), mst == 2};
    endfunction

    task automatic minit();
        for (int i = 0; i < 2; i++) begin
            mx[i] = 750 + i * 200;
            my[i] = 100 + (i * 37) % 256;
        end
        msc = 0; mstep = 1; mtick = 0; mspd = 0; m_exits = 0;
    endtask

    // Advance the game model by one clock from the current inputs, then let the DUT clock.
    task automatic cyc();
        bit [15:0] old;
        int n, py;
        bit hit;
        old = ml;
        py  = int'(player_y_i);
        ml  = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
        if (rst) begin
            minit(); mst = 0; ml = 16'hACE1;
        end else if (start_i && mst != 1) begin
            minit(); mst = 1;
        end else if (mst == 1) begin
            hit = 0;
            for (int i = 0; i < 2; i++)
                if (mx[i] < 48 && mx[i] + 32 > 0 && my[i] < py + 48 && my[i] + 32 > py) hit = 1;
            if (hit) mst = 2;
            else if (mtick == 3) begin
                mtick = 0; n = 0;
                for (int i = 0; i < 2; i++)
                    if (mx[i] < mstep) begin mx[i] = 750; my[i] = 100 + int'(old[7:0]); n++; end
                    else mx[i] -= mstep;
                msc = (msc + n > 65535) ? 65535 : msc + n;
                m_exits += n;
                mspd += n;
                if (mspd >= 5) begin mspd = 0; if (mstep < 4) mstep++; end
            end else mtick++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; cyc(); cyc(); rst = 0;
        total++;
        if ({xpos_o, ypos_o, score_o, step_o, endgame_o} !== {12'd950, 12'd750, 12'd137, 12'd100, 16'd0, 3'd1, 1'b0}) begin
            bad++; $display("FAIL reset_state: got x=%h y=%h sc=%0d st=%0d eg=%b", xpos_o, ypos_o, score_o, step_o, endgame_o);
        end
        total++;
        if ({xpos_o, ypos_o, score_o, step_o, endgame_o} !== exp_out()) begin
            bad++; $display("FAIL reset_model: got %h exp %h", {xpos_o, ypos_o, score_o, step_o, endgame_o}, exp_out());
        end
    endtask

    task automatic test_movement();
        player_y_i = 12'd900;
        start_i = 1; cyc(); start_i = 0;
        total++;
        if (xpos_o !== {12'd950, 12'd750} || endgame_o !== 1'b0) begin
            bad++; $display("FAIL start_init: got x=%h eg=%b exp x=3b62ee eg=0", xpos_o, endgame_o);
        end
        repeat (3) cyc();
        total++;
        if (xpos_o !== {12'd950, 12'd750}) begin
            bad++; $display("FAIL early_move: got x=%h exp 3b62ee", xpos_o);
        end
        cyc();
        total++;
        if (xpos_o !== {12'd949, 12'd749} || endgame_o !== 1'b0) begin
            bad++; $display("FAIL first_tick: got x=%h eg=%b exp x=3b52ed eg=0", xpos_o, endgame_o);
        end
    endtask

    task automatic test_exit_speedup();
        int prev, n = 0;
        rst = 1; cyc(); rst = 0;
        start_i = 1; cyc(); start_i = 0;
        while (m_exits < 25 && n < 40000) begin
            prev = m_exits;
            player_y_i = 12'($urandom_range(400, 4000));
            start_i = ($urandom_range(0, 15) == 0);
            cyc();
            n++;
            total++;
            if ({xpos_o, ypos_o, score_o, step_o, endgame_o} !== exp_out()) begin
                bad++; $display("FAIL run_model: got %h exp %h", {xpos_o, ypos_o, score_o, step_o, endgame_o}, exp_out());
            end
            if (prev == 0 && m_exits == 1) begin
                total++;
                if (score_o !== 16'd1 || xpos_o[11:0] !== 12'd750 || ypos_o[11:0] !== 12'(my[0])) begin
                    bad++; $display("FAIL first_exit: got sc=%0d x0=%0d y0=%0d exp 1 750 %0d", score_o, xpos_o[11:0], ypos_o[11:0], my[0]);
                end
            end
            if (prev < 5 && m_exits == 5) begin
                total++;
                if (step_o !== 3'd2) begin bad++; $display("FAIL step_after5: got %0d exp 2", step_o); end
            end
            if (prev < 20 && m_exits == 20) begin
                total++;
                if (step_o !== 3'd4) begin bad++; $display("FAIL step_after20: got %0d exp 4", step_o); end
            end
        end
        start_i = 0;
        total++;
        if (m_exits < 25 || step_o !== 3'd4) begin
            bad++; $display("FAIL step_after25: got step=%0d exits=%0d exp step 4 exits>=25", step_o, m_exits);
        end
    endtask

    task automatic test_double_exit();
        int n = 0;
        rst = 1; cyc(); rst = 0;
        player_y_i = 12'd2000;
        start_i = 1; cyc(); start_i = 0;
        while (score2_o === 16'd0 && n < 4000) begin cyc(); n++; end
        total++;
        if (score2_o !== 16'd2 || xpos2_o !== {12'd750, 12'd750} || ypos2_o[23:12] !== ypos2_o[11:0]) begin
            bad++; $display("FAIL double_exit: got sc=%0d x=%h y=%h exp sc=2 x=2ee2ee equal y", score2_o, xpos2_o, ypos2_o);
        end
        total++;
        if ({xpos_o, ypos_o, score_o, step_o, endgame_o} !== exp_out()) begin
            bad++; $display("FAIL double_model: got %h exp %h", {xpos_o, ypos_o, score_o, step_o, endgame_o}, exp_out());
        end
    endtask

    task automatic test_collision();
        int n = 0;
        logic [67:0] frozen;
        rst = 1; cyc(); rst = 0;
        player_y_i = 12'd100;
        start_i = 1; cyc(); start_i = 0;
        while (mx[0] != 47 && n < 4000) begin
            cyc(); n++;
            if (mx[0] == 48) begin
                total++;
                if (endgame_o !== 1'b0) begin bad++; $display("FAIL edge_nonoverlap: got eg=%b exp 0", endgame_o); end
            end
        end
        total++;
        if (xpos_o[11:0] !== 12'd47 || endgame_o !== 1'b0) begin
            bad++; $display("FAIL reach_47: got x0=%0d eg=%b exp 47 0", xpos_o[11:0], endgame_o);
        end
        cyc();
        total++;
        if (endgame_o !== 1'b1) begin bad++; $display("FAIL hit_latency: got eg=%b exp 1", endgame_o); end
        frozen = {xpos_o, ypos_o, score_o, step_o, endgame_o};
        repeat (80) cyc();
        total++;
        if ({xpos_o, ypos_o, score_o, step_o, endgame_o} !== frozen || frozen !== exp_out()) begin
            bad++; $display("FAIL endgame_freeze: got %h held %h exp %h", {xpos_o, ypos_o, score_o, step_o, endgame_o}, frozen, exp_out());
        end
    endtask

    task automatic test_restart();
        player_y_i = 12'd900;
        start_i = 1; cyc(); start_i = 0;
        total++;
        if ({xpos_o, score_o, step_o, endgame_o} !== {12'd950, 12'd750, 16'd0, 3'd1, 1'b0}) begin
            bad++; $display("FAIL restart: got x=%h sc=%0d st=%0d eg=%b", xpos_o, score_o, step_o, endgame_o);
        end
        repeat (4) cyc();
        start_i = 1; cyc(); start_i = 0;
        total++;
        if (xpos_o !== {12'd949, 12'd749}) begin bad++; $display("FAIL start_in_run: got x=%h exp 3b52ed", xpos_o); end
        cyc(); cyc();
        rst = 1; cyc(); rst = 0;
        total++;
        if ({xpos_o, score_o, step_o, endgame_o} !== {12'd950, 12'd750, 16'd0, 3'd1, 1'b0}) begin
            bad++; $display("FAIL rst_mid_run: got x=%h sc=%0d st=%0d eg=%b", xpos_o, score_o, step_o, endgame_o);
        end
        repeat (8) cyc();
        total++;
        if (xpos_o !== {12'd950, 12'd750}) begin bad++; $display("FAIL idle_frozen: got x=%h exp 3b62ee", xpos_o); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 499) == 0);
            start_i    = ($urandom_range(0, 63) == 0);
            player_y_i = 12'($urandom_range(0, 4000));
            if ($urandom_range(0, 3) != 0 && k > 0) player_y_i = 12'($urandom_range(60, 140));
            cyc();
            total++;
            if ({xpos_o, ypos_o, score_o, step_o, endgame_o} !== exp_out()) begin
                bad++; $display("FAIL random_model: got %h exp %h", {xpos_o, ypos_o, score_o, step_o, endgame_o}, exp_out());
            end
        end
        rst = 0; start_i = 0;
    endtask

    initial begin
        minit(); mst = 0;
        test_reset();
        test_movement();
        test_exit_speedup();
        test_double_exit();
        test_collision();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
